// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and types for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int INST_BUS      = 32;
  localparam int INST_ADDR_BUS = 32;
  localparam logic [INST_BUS-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_BUS-1:0]      inst;
    logic [INST_ADDR_BUS-1:0] addr;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_BUS-1:0] align_word(input logic [INST_ADDR_BUS-1:0] a);
    return {a[INST_ADDR_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Registered FIFO of {inst, addr}; clear empties it, data storage is not reset.
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  fetch_entry_t       wdata,
  output fetch_entry_t       rdata,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch unit: owns the PC, issues word reads, buffers responses and drops stale ones after a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
  parameter int                       DEPTH    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_mem_req_valid,
  input  logic                     i_mem_req_ready,
  output logic [INST_ADDR_BUS-1:0] o_mem_req_addr,
  input  logic                     i_mem_resp_valid,
  input  logic [INST_BUS-1:0]      i_mem_resp_data,
  output logic                     o_inst_valid,
  input  logic                     i_inst_ready,
  output logic [INST_BUS-1:0]      o_inst,
  output logic [INST_ADDR_BUS-1:0] o_inst_addr,
  input  logic                     i_ex_jump_flag,
  input  logic [INST_ADDR_BUS-1:0] i_ex_jump_addr,
  input  logic                     i_hold_flag
);

  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   CAP   = (CNT_W + 1)'(DEPTH);

  fetch_state_t             state;
  logic [INST_ADDR_BUS-1:0] req_pc;
  logic [INST_ADDR_BUS-1:0] resp_pc;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         outstanding_nxt;
  logic [CNT_W-1:0]         drop;
  logic [CNT_W-1:0]         drop_nxt;
  logic [CNT_W-1:0]         count;
  logic [CNT_W:0]           inflight;
  logic                     full;
  logic                     empty;
  logic                     req_fire;
  logic                     push;
  logic                     pop;
  fetch_entry_t             head;
  fetch_entry_t             wentry;

  // Requests only in FETCH, and never more than DEPTH words promised to the buffer.
  assign inflight        = {1'b0, outstanding} + {1'b0, count};
  assign o_mem_req_valid = (state == FETCH) && !i_hold_flag && !i_ex_jump_flag && (inflight < CAP);
  assign o_mem_req_addr  = req_pc;
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;

  assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(i_mem_resp_valid);
  assign drop_nxt        = (i_mem_resp_valid && (drop != '0)) ? drop - 1'b1 : drop;

  assign push   = i_mem_resp_valid && !i_ex_jump_flag && (drop == '0);
  assign pop    = o_inst_valid && i_inst_ready && !i_ex_jump_flag;
  assign wentry = '{inst: i_mem_resp_data, addr: resp_pc};

  assign o_inst_valid = !empty;
  assign o_inst       = empty ? INST_NOP : head.inst;
  assign o_inst_addr  = empty ? '0 : head.addr;

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .clear (i_ex_jump_flag),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      req_pc      <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (i_ex_jump_flag) begin
        // Everything still in flight belongs to the old stream.
        req_pc  <= align_word(i_ex_jump_addr);
        resp_pc <= align_word(i_ex_jump_addr);
        drop    <= outstanding_nxt;
        state   <= (outstanding_nxt != '0) ? DRAIN : FETCH;
      end else begin
        if (req_fire) req_pc  <= req_pc + 32'd4;
        if (push)     resp_pc <= resp_pc + 32'd4;
        drop <= drop_nxt;
        case (state)
          IDLE:    state <= FETCH;
          FETCH:   state <= FETCH;
          DRAIN:   if (drop_nxt == '0) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && full && !pop));

endmodule
